// File: rtl/phy_serial_link_pkg.sv
// Shared types and default symbols for the serial PHY link.
// Both the transmit top and the receive sub-module import this package.
package phy_serial_link_pkg;

    typedef enum logic {
        TX_TRAIN = 1'b0,
        TX_DATA  = 1'b1
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_HUNT   = 2'd0,
        RX_TRAIN  = 2'd1,
        RX_ACTIVE = 2'd2
    } rx_state_e;

    localparam logic [7:0] DEFAULT_COM  = 8'hBC;
    localparam logic [7:0] DEFAULT_IDLE = 8'h7C;

endpackage

// File: rtl/phy_serial_rx.sv
// Receive path: hunts for COM, trains on consecutive aligned COMs,
// then deserialises boundary words and demultiplexes them onto lanes.
module phy_serial_rx
    import phy_serial_link_pkg::*;
#(
    parameter int               LANES       = 4,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] COM         = WIDTH'(DEFAULT_COM),
    parameter logic [WIDTH-1:0] IDLE        = WIDTH'(DEFAULT_IDLE),
    parameter int               ALIGN_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     serial_in,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_valid,
    output logic                     active
);

    localparam int BW = $clog2(WIDTH);
    localparam int LW = $clog2(LANES);
    localparam int CW = $clog2(ALIGN_COUNT + 1);

    rx_state_e              state_q;
    logic [WIDTH-1:0]       sr_q;
    logic [WIDTH-1:0]       word_d;
    logic [BW-1:0]          bit_cnt_q;
    logic [CW-1:0]          com_cnt_q;
    logic [LW-1:0]          lane_q;
    logic [LW-1:0]          lane_next;
    logic                   boundary;
    logic                   dlv_q;
    logic [LW-1:0]          dlv_lane_q;
    logic [WIDTH-1:0]       dlv_word_q;
    logic                   active_q;
    logic [LANES*WIDTH-1:0] out_data_q;
    logic [LANES-1:0]       out_valid_q;

    // The word including the bit arriving this cycle, so decisions land on the word's last bit.
    assign word_d    = {sr_q[WIDTH-2:0], serial_in};
    assign boundary  = (bit_cnt_q == BW'(WIDTH - 1));
    assign lane_next = (lane_q == LW'(LANES - 1)) ? '0 : lane_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RX_HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            com_cnt_q   <= '0;
            lane_q      <= '0;
            dlv_q       <= 1'b0;
            dlv_lane_q  <= '0;
            dlv_word_q  <= '0;
            active_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else begin
            sr_q        <= word_d;
            bit_cnt_q   <= boundary ? '0 : bit_cnt_q + 1'b1;
            dlv_q       <= 1'b0;
            out_valid_q <= '0;

            // Delivered words pass through one output stage before reaching the lane registers.
            if (dlv_q) begin
                for (int i = 0; i < LANES; i++) begin
                    if (dlv_lane_q == LW'(i)) begin
                        out_data_q[i*WIDTH +: WIDTH] <= dlv_word_q;
                        out_valid_q[i]               <= 1'b1;
                    end
                end
            end

            case (state_q)
                RX_HUNT: begin
                    if (word_d == COM) begin
                        bit_cnt_q <= '0;
                        com_cnt_q <= CW'(1);
                        if (ALIGN_COUNT == 1) begin
                            state_q  <= RX_ACTIVE;
                            active_q <= 1'b1;
                            lane_q   <= '0;
                        end else begin
                            state_q <= RX_TRAIN;
                        end
                    end
                end
                RX_TRAIN: begin
                    if (boundary) begin
                        if (word_d == COM) begin
                            com_cnt_q <= com_cnt_q + 1'b1;
                            if (com_cnt_q == CW'(ALIGN_COUNT - 1)) begin
                                state_q  <= RX_ACTIVE;
                                active_q <= 1'b1;
                                lane_q   <= '0;
                            end
                        end else begin
                            state_q   <= RX_HUNT;
                            com_cnt_q <= '0;
                        end
                    end
                end
                RX_ACTIVE: begin
                    // A COM here means the transmitter is retraining, so realign the lane order.
                    if (boundary) begin
                        if (word_d == COM) begin
                            lane_q <= '0;
                        end else if (word_d == IDLE) begin
                            lane_q <= lane_next;
                        end else begin
                            dlv_q      <= 1'b1;
                            dlv_lane_q <= lane_q;
                            dlv_word_q <= word_d;
                            lane_q     <= lane_next;
                        end
                    end
                end
                default: state_q <= RX_HUNT;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign active    = active_q;

endmodule

// File: rtl/phy_serial_link.sv
// Single-clock serial PHY link: round-robin lane transmitter with COM training
// and IDLE fill, plus the receive path instantiated from phy_serial_rx.
module phy_serial_link
    import phy_serial_link_pkg::*;
#(
    parameter int               LANES       = 4,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] COM         = WIDTH'(DEFAULT_COM),
    parameter logic [WIDTH-1:0] IDLE        = WIDTH'(DEFAULT_IDLE),
    parameter int               TRAIN_WORDS = 8,
    parameter int               ALIGN_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_valid,
    output logic [LANES-1:0]       in_take,
    output logic                   serial_out,
    input  logic                   serial_in,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_valid,
    output logic                   active
);

    localparam int BW = $clog2(WIDTH);
    localparam int LW = $clog2(LANES);
    localparam int TW = $clog2(TRAIN_WORDS);

    tx_state_e        tx_state_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [LW-1:0]    lane_cnt_q;
    logic [TW-1:0]    train_cnt_q;
    logic [WIDTH-1:0] tx_sr_q;
    logic [LANES-1:0] in_take_q;
    logic [WIDTH-1:0] lane_word;
    logic             word_end;
    logic             take_pending;

    assign word_end = (bit_cnt_q == BW'(WIDTH - 1));
    // The next slot carries lane data once training is over or its last COM is on the line.
    assign take_pending = (tx_state_q == TX_DATA) || (train_cnt_q == TW'(TRAIN_WORDS - 1));

    always_comb begin
        lane_word = IDLE;
        for (int i = 0; i < LANES; i++) begin
            if ((lane_cnt_q == LW'(i)) && in_valid[i]) begin
                lane_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= TX_TRAIN;
            bit_cnt_q   <= '0;
            lane_cnt_q  <= '0;
            train_cnt_q <= '0;
            tx_sr_q     <= COM;
            in_take_q   <= '0;
        end else begin
            in_take_q <= '0;
            if ((bit_cnt_q == BW'(WIDTH - 2)) && take_pending) begin
                in_take_q <= LANES'(1) << lane_cnt_q;
            end
            if (word_end) begin
                bit_cnt_q <= '0;
                if (take_pending) begin
                    tx_state_q <= TX_DATA;
                    tx_sr_q    <= lane_word;
                    lane_cnt_q <= (lane_cnt_q == LW'(LANES - 1)) ? '0 : lane_cnt_q + 1'b1;
                end else begin
                    tx_sr_q     <= COM;
                    train_cnt_q <= train_cnt_q + 1'b1;
                end
            end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                tx_sr_q   <= {tx_sr_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // The shifter resets holding the first COM so its MSB is on the line right after release.
    assign serial_out = tx_sr_q[WIDTH-1] & ~reset;
    assign in_take    = in_take_q;

    phy_serial_rx #(
        .LANES       (LANES),
        .WIDTH       (WIDTH),
        .COM         (COM),
        .IDLE        (IDLE),
        .ALIGN_COUNT (ALIGN_COUNT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .active    (active)
    );

endmodule

// File: tb/tb_phy_serial_link.sv
// Directed loopback bench for phy_serial_link; cycle n counts rising edges
// since reset release, with checks taken mid-cycle.
module tb_phy_serial_link;

    logic        clk;
    logic        reset;
    logic [31:0] inData;
    logic [3:0]  inValid;
    logic [3:0]  inTake;
    logic        serialOut;
    logic        serialIn;
    logic [31:0] outData;
    logic [3:0]  outValid;
    logic        active;

    logic        delayMode;
    logic        flip;
    logic        injEn;
    logic        injBit;
    logic [2:0]  dly;
    logic [7:0]  comWord;

    int cyc;
    int checkCount;
    int passCount;

    phy_serial_link dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (inData),
        .in_valid   (inValid),
        .in_take    (inTake),
        .serial_out (serialOut),
        .serial_in  (serialIn),
        .out_data   (outData),
        .out_valid  (outValid),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) dly <= {dly[1:0], serialOut};

    always_comb begin
        serialIn = (injEn ? injBit : (delayMode ? dly[2] : serialOut)) ^ flip;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] valid);
        inData  = data;
        inValid = valid;
    endtask

    task automatic waitCycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        #3;
    endtask

    task automatic releaseReset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1 reset = 1'b1;
        releaseReset();
    endtask

    initial begin
        reset      = 1'b1;
        delayMode  = 1'b0;
        flip       = 1'b0;
        injEn      = 1'b0;
        injBit     = 1'b0;
        dly        = 3'b000;
        comWord    = 8'hBC;
        cyc        = 0;
        checkCount = 0;
        passCount  = 0;
        applyStimulus(32'h44332211, 4'b1111);

        #2;
        checkOutput("rst_serial_out", {31'd0, serialOut}, 32'd0);
        checkOutput("rst_in_take", {28'd0, inTake}, 32'd0);
        checkOutput("rst_out_valid", {28'd0, outValid}, 32'd0);
        checkOutput("rst_out_data", outData, 32'd0);
        checkOutput("rst_active", {31'd0, active}, 32'd0);

        // Basic loopback with all lanes valid.
        releaseReset();
        waitCycle(0);  checkOutput("com_msb", {31'd0, serialOut}, 32'd1);
        waitCycle(1);  checkOutput("com_bit6", {31'd0, serialOut}, 32'd0);
        waitCycle(7);  checkOutput("take_in_train", {28'd0, inTake}, 32'd0);
        waitCycle(31); checkOutput("active_c31", {31'd0, active}, 32'd0);
        waitCycle(32); checkOutput("active_c32", {31'd0, active}, 32'd1);
        waitCycle(63); checkOutput("take_lane0", {28'd0, inTake}, 32'h1);
        waitCycle(71); checkOutput("take_lane1", {28'd0, inTake}, 32'h2);
        waitCycle(72); checkOutput("valid_c72", {28'd0, outValid}, 32'h0);
        waitCycle(73); checkOutput("valid_lane0", {28'd0, outValid}, 32'h1);
                       checkOutput("data_lane0", {24'd0, outData[7:0]}, 32'h11);
        waitCycle(81); checkOutput("valid_lane1", {28'd0, outValid}, 32'h2);
                       checkOutput("data_lane1", {24'd0, outData[15:8]}, 32'h22);
        waitCycle(89); checkOutput("valid_lane2", {28'd0, outValid}, 32'h4);
        waitCycle(90); applyStimulus(32'h88776655, 4'b0101);
        waitCycle(97); checkOutput("valid_lane3", {28'd0, outValid}, 32'h8);
                       checkOutput("data_all", outData, 32'h44332211);

        // Lanes 1 and 3 idle: their slots carry IDLE and their outputs hold.
        waitCycle(105); checkOutput("idle_valid0", {28'd0, outValid}, 32'h1);
                        checkOutput("idle_data0", {24'd0, outData[7:0]}, 32'h55);
        waitCycle(113); checkOutput("idle_valid1", {28'd0, outValid}, 32'h0);
        waitCycle(121); checkOutput("idle_valid2", {28'd0, outValid}, 32'h4);
        waitCycle(129); checkOutput("idle_valid3", {28'd0, outValid}, 32'h0);
                        checkOutput("idle_data_all", outData, 32'h44772255);

        // Reset in the middle of a data word, then COM injection while active.
        waitCycle(132);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_active", {31'd0, active}, 32'd0);
        checkOutput("mid_rst_data", outData, 32'd0);
        checkOutput("mid_rst_valid", {28'd0, outValid}, 32'd0);
        checkOutput("mid_rst_serial", {31'd0, serialOut}, 32'd0);
        checkOutput("mid_rst_take", {28'd0, inTake}, 32'd0);
        applyStimulus(32'h44332211, 4'b1111);
        releaseReset();
        waitCycle(31); checkOutput("re_active_c31", {31'd0, active}, 32'd0);
        waitCycle(32); checkOutput("re_active_c32", {31'd0, active}, 32'd1);
        for (int j = 0; j < 8; j++) begin
            waitCycle(72 + j);
            if (j == 1) begin
                checkOutput("re_valid_lane0", {28'd0, outValid}, 32'h1);
                checkOutput("re_data_lane0", {24'd0, outData[7:0]}, 32'h11);
            end
            injEn  = 1'b1;
            injBit = comWord[7-j];
        end
        waitCycle(80); injEn = 1'b0;
        waitCycle(81); checkOutput("inj_no_valid", {28'd0, outValid}, 32'h0);
        waitCycle(89); checkOutput("inj_valid_lane0", {28'd0, outValid}, 32'h1);
                       checkOutput("inj_data_lane0", {24'd0, outData[7:0]}, 32'h33);
                       checkOutput("inj_active", {31'd0, active}, 32'd1);

        // Serial path delayed by three bit times.
        delayMode = 1'b1;
        applyReset();
        waitCycle(34); checkOutput("dly_active_c34", {31'd0, active}, 32'd0);
        waitCycle(35); checkOutput("dly_active_c35", {31'd0, active}, 32'd1);
        waitCycle(75); checkOutput("dly_valid_c75", {28'd0, outValid}, 32'h0);
        waitCycle(76); checkOutput("dly_valid_lane0", {28'd0, outValid}, 32'h1);
                       checkOutput("dly_data_lane0", {24'd0, outData[7:0]}, 32'h11);
        waitCycle(84); checkOutput("dly_valid_lane1", {28'd0, outValid}, 32'h2);

        // LSB of the second training COM corrupted.
        delayMode = 1'b0;
        applyReset();
        waitCycle(15); flip = 1'b1;
        waitCycle(16); flip = 1'b0;
        waitCycle(32); checkOutput("flip_active_c32", {31'd0, active}, 32'd0);
        waitCycle(47); checkOutput("flip_active_c47", {31'd0, active}, 32'd0);
        waitCycle(48); checkOutput("flip_active_c48", {31'd0, active}, 32'd1);
        waitCycle(73); checkOutput("flip_valid_lane0", {28'd0, outValid}, 32'h1);
                       checkOutput("flip_data_lane0", {24'd0, outData[7:0]}, 32'h11);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
